fpdiv: RTL and testbench
========================

// Module: fpdiv
// PURPOSE
//  Sequential IEEE-754 single-precision divider, P = A / B; the inverse of the fpmul unit, same Start/Done handshake and flag set.
//  Holds a control FSM and a datapath in one module: unpack, restoring mantissa division (1 quotient bit/cycle), normalize, RNE round, pack.
//  Sits beside fpmul in the FP unit; shares its operand buses and result/flag conventions. Denormals are flushed to zero (DAZ/FTZ).
// PARAMETERS
//  EXP_W    8    exponent width (bias = 2^(EXP_W-1)-1 = 127)
//  MAN_W    23   stored fraction width; quotient iterations QN = MAN_W+3 = 26
// PORTS
//  Clk    in   1         clock, all state on rising edge
//  Rst    in   1         asynchronous, active-low reset
//  Start  in   1         request; sampled only in IDLE
//  A      in   32        dividend (sign|exp|frac)
//  B      in   32        divisor
//  Done   out  1         one-cycle pulse: P and flags valid
//  P      out  32        quotient, registered, held until next accepted Start
//  UF     out  1         underflow (result flushed to +/-0)
//  OF     out  1         overflow (result forced to +/-Inf)
//  NaNF   out  1         result is NaN
//  InfF   out  1         result is +/-Inf
//  DNF    out  1         at least one denormal operand was flushed to zero
//  ZF     out  1         result is +/-0
//  DZF    out  1         divide by zero (finite nonzero / 0)
// BEHAVIOUR
//  Reset (Rst=0, any state, incl. mid-division): state=IDLE, Done=0, P=0, all flags 0, internal regs 0; async assert, sync deassert.
//  States: IDLE -> LOAD -> (special ? DONE : DIV) ; DIV x QN -> NORM -> DONE -> IDLE.
//  IDLE: Start=1 on edge E0 latches A,B; clears P and flags; -> LOAD. Start outside IDLE ignored (no queueing).
//  LOAD: unpack; denormal operand -> treated as 0, DNF=1. Sign S = SA^SB. Special detect with priority:
//   NaN in A or B, 0/0, Inf/Inf -> P=0x7FC00000, NaNF.  Inf/x -> S|Inf, InfF.  x/0 -> S|Inf, InfF, DZF.
//   0/x or x/Inf -> S|0, ZF.  Specials: Done=1 in cycle after edge E0+2.
//  Normal: Eq = EA - EB + 127 in (EXP_W+2)-bit signed; R = {1,fracA}, D = {1,fracB}.
//  DIV: QN cycles, restoring: if R>=D {q=1; R=R-D} else q=0; R=R<<1; q shifted into Q[QN-1:0] (MSB weight 2^0).
//  NORM: if Q[25]=1: sig=Q[25:2], G=Q[1], St=Q[0]|(R!=0); else sig=Q[24:1], G=Q[0], St=(R!=0), Eq=Eq-1.
//   RNE: round up iff G & (St | sig[0]); carry out -> sig=1.0, Eq=Eq+1.
//   Eq>=255 -> P=S|0x7F800000, OF, InfF.  Eq<=0 -> P=S|0, UF, ZF (no gradual underflow).  else P={S,Eq[7:0],sig[22:0]}.
//  Normal latency: Done=1 in cycle after edge E0+29 (LOAD 1 + DIV 26 + NORM 1 + DONE 1).
//  DONE: Done=1 exactly one cycle; P/flags stable from that cycle until the next accepted Start.
//  Start=1 during DONE cycle ignored; Start held high re-accepted in following IDLE cycle.
//  NaN output always canonical 0x7FC00000, sign ignored; flags mutually consistent (ZF with UF, InfF with OF).
// TESTING
//  6.0/2.0: A=0x40C00000 B=0x40000000 -> P=0x40400000, all flags 0, Done at E0+29 only.
//  1.0/3.0: A=0x3F800000 B=0x40400000 -> P=0x3EAAAAAB (round up); -1.0/3.0 -> 0xBEAAAAAB.
//  Specials: 1.0/0 -> 0x7F800000 InfF DZF; 0/0 -> 0x7FC00000 NaNF; 0x7FC00001/1.0 -> 0x7FC00000 NaNF; Done at E0+2.
//  Range: 0x7F000000/0x3E800000 -> 0x7F800000 OF InfF; 0x00800000/0x40000000 -> 0x00000000 UF ZF.
//  Denormal: 0x00000001/0x3F800000 -> P=0x00000000 DNF ZF; 0x3F800000/0x80000001 -> 0xFF800000 DNF InfF DZF.
//  Control: Rst=0 at E0+10 -> Done/P/flags 0, IDLE; Start pulsed at E0+5 with new A/B is ignored, first result unchanged.

Source files
------------

// File: rtl/fpdiv.sv
// Sequential single-precision divider P = A / B: restoring mantissa division, one quotient bit
// per cycle, RNE rounding, denormal operands flushed to zero, no gradual underflow on the result.
module fpdiv #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   done,
    output logic [EXP_W+MAN_W:0]   p,
    output logic                   uf,
    output logic                   of,
    output logic                   nanf,
    output logic                   inff,
    output logic                   dnf,
    output logic                   zf,
    output logic                   dzf
);
    localparam int W     = EXP_W + MAN_W + 1;
    localparam int SIG_W = MAN_W + 1;
    localparam int QN    = MAN_W + 3;
    localparam int CW    = $clog2(QN);
    localparam int EW    = EXP_W + 2;

    localparam logic [EW-1:0]    BIAS     = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic [EW-1:0]    EMAX     = EW'((1 << EXP_W) - 1);
    localparam logic [EW-1:0]    ONE_E    = EW'(1);
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [CW-1:0]    CNT_INIT = CW'(QN - 1);
    localparam logic [W-1:0]     QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};

    typedef enum logic [2:0] {IDLE, LOAD, DIV, NORM, DONE} state_t;

    state_t            state_reg;
    logic [W-1:0]      op_reg [2];
    logic              sign_reg;
    logic [EW-1:0]     exp_reg;
    logic [SIG_W:0]    rem_reg;
    logic [SIG_W-1:0]  div_reg;
    logic [QN-1:0]     quo_reg;
    logic [CW-1:0]     cnt_reg;
    logic              done_reg;
    logic [W-1:0]      p_reg;
    logic              uf_reg, of_reg, nanf_reg, inff_reg, dnf_reg, zf_reg, dzf_reg;

    // Operand 0 is the dividend, operand 1 the divisor; a denormal counts as zero.
    logic [EXP_W-1:0]  op_exp  [2];
    logic [MAN_W-1:0]  op_frac [2];
    logic [1:0]        op_sign, op_nan, op_inf, op_zero, op_den;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            assign op_sign[gi] = op_reg[gi][W-1];
            assign op_exp[gi]  = op_reg[gi][W-2:MAN_W];
            assign op_frac[gi] = op_reg[gi][MAN_W-1:0];
            assign op_nan[gi]  = (op_exp[gi] == EXP_ONES) && (op_frac[gi] != '0);
            assign op_inf[gi]  = (op_exp[gi] == EXP_ONES) && (op_frac[gi] == '0);
            assign op_zero[gi] = (op_exp[gi] == '0);
            assign op_den[gi]  = (op_exp[gi] == '0) && (op_frac[gi] != '0);
        end
    endgenerate

    logic              res_sign;
    logic [EW-1:0]     exp_load;
    assign res_sign = op_sign[0] ^ op_sign[1];
    assign exp_load = {2'b00, op_exp[0]} - {2'b00, op_exp[1]} + BIAS;

    // Restoring step: the partial remainder stays below 2*D, so one guard bit suffices.
    logic              rem_ge;
    logic [SIG_W:0]    rem_diff, rem_sub, rem_next;
    assign rem_ge   = rem_reg >= {1'b0, div_reg};
    assign rem_diff = rem_reg - {1'b0, div_reg};
    assign rem_sub  = rem_ge ? rem_diff : rem_reg;
    assign rem_next = rem_sub << 1;

    // Quotient lies in (0.5, 2); the hidden bit is always set after normalisation, so a carry
    // out of the fraction alone signals mantissa overflow to 2.0.
    logic              norm_top, guard, sticky, round_up, carry;
    logic [MAN_W-1:0]  sig_frac;
    logic [MAN_W:0]    frac_rnd;
    logic [EW-1:0]     exp_norm;
    logic              exp_ovf, exp_unf;
    assign norm_top = quo_reg[QN-1];
    assign sig_frac = norm_top ? quo_reg[QN-2:2] : quo_reg[QN-3:1];
    assign guard    = norm_top ? quo_reg[1] : quo_reg[0];
    assign sticky   = (norm_top & quo_reg[0]) | (rem_reg != '0);
    assign round_up = guard & (sticky | sig_frac[0]);
    assign frac_rnd = {1'b0, sig_frac} + {{MAN_W{1'b0}}, round_up};
    assign carry    = frac_rnd[MAN_W];
    assign exp_norm = exp_reg - (norm_top ? '0 : ONE_E) + (carry ? ONE_E : '0);
    assign exp_ovf  = $signed(exp_norm) >= $signed(EMAX);
    assign exp_unf  = exp_norm[EW-1] || (exp_norm == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            op_reg[0] <= '0;
            op_reg[1] <= '0;
            sign_reg  <= 1'b0;
            exp_reg   <= '0;
            rem_reg   <= '0;
            div_reg   <= '0;
            quo_reg   <= '0;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
            p_reg     <= '0;
            uf_reg    <= 1'b0;
            of_reg    <= 1'b0;
            nanf_reg  <= 1'b0;
            inff_reg  <= 1'b0;
            dnf_reg   <= 1'b0;
            zf_reg    <= 1'b0;
            dzf_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        op_reg[0] <= a;
                        op_reg[1] <= b;
                        p_reg     <= '0;
                        uf_reg    <= 1'b0;
                        of_reg    <= 1'b0;
                        nanf_reg  <= 1'b0;
                        inff_reg  <= 1'b0;
                        dnf_reg   <= 1'b0;
                        zf_reg    <= 1'b0;
                        dzf_reg   <= 1'b0;
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    sign_reg  <= res_sign;
                    dnf_reg   <= |op_den;
                    state_reg <= DONE;
                    if ((|op_nan) || (&op_zero) || (&op_inf)) begin
                        p_reg    <= QNAN;
                        nanf_reg <= 1'b1;
                    end else if (op_inf[0]) begin
                        p_reg    <= {res_sign, EXP_ONES, {MAN_W{1'b0}}};
                        inff_reg <= 1'b1;
                    end else if (op_zero[1]) begin
                        p_reg    <= {res_sign, EXP_ONES, {MAN_W{1'b0}}};
                        inff_reg <= 1'b1;
                        dzf_reg  <= 1'b1;
                    end else if (op_zero[0] || op_inf[1]) begin
                        p_reg    <= {res_sign, {(W - 1){1'b0}}};
                        zf_reg   <= 1'b1;
                    end else begin
                        exp_reg   <= exp_load;
                        rem_reg   <= {2'b01, op_frac[0]};
                        div_reg   <= {1'b1, op_frac[1]};
                        quo_reg   <= '0;
                        cnt_reg   <= CNT_INIT;
                        state_reg <= DIV;
                    end
                end
                DIV: begin
                    rem_reg <= rem_next;
                    quo_reg <= {quo_reg[QN-2:0], rem_ge};
                    cnt_reg <= cnt_reg - CW'(1);
                    if (cnt_reg == '0)
                        state_reg <= NORM;
                end
                NORM: begin
                    if (exp_ovf) begin
                        p_reg    <= {sign_reg, EXP_ONES, {MAN_W{1'b0}}};
                        of_reg   <= 1'b1;
                        inff_reg <= 1'b1;
                    end else if (exp_unf) begin
                        p_reg    <= {sign_reg, {(W - 1){1'b0}}};
                        uf_reg   <= 1'b1;
                        zf_reg   <= 1'b1;
                    end else begin
                        p_reg    <= {sign_reg, exp_norm[EXP_W-1:0], frac_rnd[MAN_W-1:0]};
                    end
                    state_reg <= DONE;
                end
                DONE: begin
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign done = done_reg;
    assign p    = p_reg;
    assign uf   = uf_reg;
    assign of   = of_reg;
    assign nanf = nanf_reg;
    assign inff = inff_reg;
    assign dnf  = dnf_reg;
    assign zf   = zf_reg;
    assign dzf  = dzf_reg;
endmodule

// File: tb/tb_fpdiv.sv
// Scoreboard bench for fpdiv: stimulus pushes hand-computed results and latencies, a monitor
// pops and compares on every Done pulse.
module tb_fpdiv;
    localparam logic [6:0] F_UF  = 7'b1000000;
    localparam logic [6:0] F_OF  = 7'b0100000;
    localparam logic [6:0] F_NAN = 7'b0010000;
    localparam logic [6:0] F_INF = 7'b0001000;
    localparam logic [6:0] F_DN  = 7'b0000100;
    localparam logic [6:0] F_Z   = 7'b0000010;
    localparam logic [6:0] F_DZ  = 7'b0000001;
    localparam int LAT_N = 30;
    localparam int LAT_S = 3;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        done;
    logic [31:0] p;
    logic        uf, of, nanf, inff, dnf, zf, dzf;
    logic [6:0]  flags;
    assign flags = {uf, of, nanf, inff, dnf, zf, dzf};

    int cyc       = 0;
    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [31:0] p;
        logic [6:0]  f;
        int          issue;
        int          lat;
        string       name;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    fpdiv dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .done  (done),
        .p     (p),
        .uf    (uf),
        .of    (of),
        .nanf  (nanf),
        .inff  (inff),
        .dnf   (dnf),
        .zf    (zf),
        .dzf   (dzf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: actual=%08h required=%08h", name, act, req);
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_done: actual=done at cycle %0d required=no result pending", cyc);
            end else begin
                mon_e = sb.pop_front();
                $display("txn %s: P=%08h flags=%07b latency=%0d", mon_e.name, p, flags, cyc - mon_e.issue);
                check({mon_e.name, "_p"}, p, mon_e.p);
                check({mon_e.name, "_flags"}, {25'b0, flags}, {25'b0, mon_e.f});
                check({mon_e.name, "_latency"}, 32'(cyc - mon_e.issue), 32'(mon_e.lat));
            end
        end
    end

    task automatic push_exp(input logic [31:0] pe, input logic [6:0] fe, input int lat, input string name);
        exp_t e;
        e.p = pe; e.f = fe; e.issue = cyc; e.lat = lat; e.name = name;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            total_cnt++;
            $display("FAIL %s_timeout: actual=no done in 100 cycles required=done", name);
        end
    endtask

    task automatic run_vec(input logic [31:0] av, input logic [31:0] bv, input logic [31:0] pe,
                           input logic [6:0] fe, input int lat, input string name);
        drive(av, bv);
        push_exp(pe, fe, lat, name);
        @(negedge clk);
        start = 1'b0;
        wait_done(name);
        @(negedge clk);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_p", p, 32'h0);
        check("rst_flags", {25'b0, flags}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        run_vec(32'h40C00000, 32'h40000000, 32'h40400000, 7'b0,            LAT_N, "six_by_two");
        run_vec(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 7'b0,            LAT_N, "one_by_three");
        run_vec(32'hBF800000, 32'h40400000, 32'hBEAAAAAB, 7'b0,            LAT_N, "neg_one_by_three");
        run_vec(32'h40000000, 32'hBF000000, 32'hC0800000, 7'b0,            LAT_N, "two_by_neg_half");
        run_vec(32'h3F800000, 32'h00000000, 32'h7F800000, F_INF | F_DZ,    LAT_S, "one_by_zero");
        run_vec(32'h00000000, 32'h00000000, 32'h7FC00000, F_NAN,           LAT_S, "zero_by_zero");
        run_vec(32'h7FC00001, 32'h3F800000, 32'h7FC00000, F_NAN,           LAT_S, "nan_in");
        run_vec(32'h7F800000, 32'hFF800000, 32'h7FC00000, F_NAN,           LAT_S, "inf_by_inf");
        run_vec(32'hFF800000, 32'h40000000, 32'hFF800000, F_INF,           LAT_S, "neg_inf_by_two");
        run_vec(32'hC0000000, 32'h7F800000, 32'h80000000, F_Z,             LAT_S, "neg_by_inf");
        run_vec(32'h7F000000, 32'h3E800000, 32'h7F800000, F_OF | F_INF,   LAT_N, "overflow");
        run_vec(32'hFF000000, 32'h3E800000, 32'hFF800000, F_OF | F_INF,   LAT_N, "neg_overflow");
        run_vec(32'h00800000, 32'h40000000, 32'h00000000, F_UF | F_Z,     LAT_N, "underflow");
        run_vec(32'h00800000, 32'hC0000000, 32'h80000000, F_UF | F_Z,     LAT_N, "neg_underflow");
        run_vec(32'h00000001, 32'h3F800000, 32'h00000000, F_DN | F_Z,     LAT_S, "denorm_a");
        run_vec(32'h3F800000, 32'h80000001, 32'hFF800000, F_DN | F_INF | F_DZ, LAT_S, "denorm_b");

        // A second Start mid-division must not disturb the first result.
        drive(32'h40C00000, 32'h40000000);
        push_exp(32'h40400000, 7'b0, LAT_N, "ignored_start");
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        drive(32'h3F800000, 32'h40400000);
        @(negedge clk);
        start = 1'b0;
        wait_done("ignored_start");
        @(negedge clk);

        // Start held high: ignored in the DONE cycle, re-accepted in the following IDLE cycle.
        drive(32'h3F800000, 32'h40400000);
        push_exp(32'h3EAAAAAB, 7'b0, LAT_N, "held_first");
        wait_done("held_first");
        push_exp(32'h3EAAAAAB, 7'b0, LAT_N, "held_second");
        @(negedge clk);
        start = 1'b0;
        wait_done("held_second");
        @(negedge clk);

        // Reset while a result is held clears it.
        rst_n = 1'b0;
        #1;
        check("rst_held_p", p, 32'h0);
        check("rst_held_done", {31'b0, done}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-division at E0+10: no result may appear afterwards.
        drive(32'h40C00000, 32'h40000000);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_p", p, 32'h0);
        check("rst_mid_done", {31'b0, done}, 32'h0);
        check("rst_mid_flags", {25'b0, flags}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        run_vec(32'h40000000, 32'hBF000000, 32'hC0800000, 7'b0, LAT_N, "after_reset");

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
